// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the two-requester AES job scheduler.
// The job key field is sized for the widest AES key; narrower keys are zero-extended.
package aes_sched_pkg;

  localparam int REQS      = 2;
  localparam int KEY_MAX_W = 256;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    KEY,
    RUN,
    RESP,
    GAP
  } state_t;

  typedef struct packed {
    logic                 dec;
    logic [127:0]         data;
    logic [KEY_MAX_W-1:0] key;
  } job_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves past the winner only when advance is set.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       win
);

  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (req[ptr]) begin
      grant[ptr] = 1'b1;
    end else if (req[~ptr]) begin
      grant[~ptr] = 1'b1;
    end
  end

  assign win = grant[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 1'b0;
    end else if (advance && (|req)) begin
      ptr <= ~win;
    end
  end

endmodule

// File: rtl/aes_job_scheduler.sv
// Shares one AES engine between two requesters: round-robin grant, key-cache reuse,
// enable sequencing with a timeout, and a valid/ack response per job.
module aes_job_scheduler
  import aes_sched_pkg::*;
#(
  parameter int Nk      = 4,
  parameter int Nr      = 10,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REQS-1:0]       req,
  input  logic [REQS-1:0]       req_dec,
  input  logic [REQS*128-1:0]   req_data,
  input  logic [REQS*Nk*32-1:0] req_key,
  output logic [REQS-1:0]       gnt,
  output logic [REQS-1:0]       rsp_valid,
  input  logic [REQS-1:0]       rsp_ack,
  output logic [127:0]          rsp_data,
  output logic                  rsp_err,
  output logic                  kx_en,
  output logic [Nk*32-1:0]      kx_key,
  input  logic                  kx_done,
  output logic                  enc_en,
  output logic                  dec_en,
  output logic [127:0]          eng_data,
  input  logic                  enc_done,
  input  logic                  dec_done,
  input  logic [127:0]          enc_out,
  input  logic [127:0]          dec_out
);

  localparam int KW = Nk * 32;
  localparam int CW = $clog2(TIMEOUT + 1);

  // The round count belongs to the engine; an inconsistent pair is visible in the hierarchy.
  if (Nr != Nk + 6) begin : g_nr_mismatch
  end

  state_t               state, state_next;
  job_t                 job, job_next;
  logic                 owner, owner_next;
  logic                 key_cached_valid, key_cached_valid_next;
  logic [KEY_MAX_W-1:0] cached_key, cached_key_next;
  logic [CW-1:0]        tmo_cnt, tmo_cnt_next;
  logic                 gap_to_run, gap_to_run_next;
  logic [127:0]         rsp_data_r, rsp_data_next;
  logic                 rsp_err_r, rsp_err_next;

  logic [1:0]           arb_grant;
  logic                 arb_win;
  logic                 arb_advance;
  logic [127:0]         data_sel;
  logic [KEY_MAX_W-1:0] key_sel;
  logic                 tmo_hit;
  logic                 done_match;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (arb_advance),
    .grant   (arb_grant),
    .win     (arb_win)
  );

  assign data_sel   = arb_win ? req_data[2*128-1:128] : req_data[127:0];
  assign key_sel    = KEY_MAX_W'(arb_win ? req_key[2*KW-1:KW] : req_key[KW-1:0]);
  assign tmo_hit    = (tmo_cnt == CW'(TIMEOUT));
  assign done_match = (job.dec == MODE_DEC) ? dec_done : enc_done;
  assign arb_advance = (state == IDLE) && (|req);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      job              <= '0;
      owner            <= 1'b0;
      key_cached_valid <= 1'b0;
      cached_key       <= '0;
      tmo_cnt          <= '0;
      gap_to_run       <= 1'b0;
      rsp_data_r       <= '0;
      rsp_err_r        <= 1'b0;
    end else begin
      state            <= state_next;
      job              <= job_next;
      owner            <= owner_next;
      key_cached_valid <= key_cached_valid_next;
      cached_key       <= cached_key_next;
      tmo_cnt          <= tmo_cnt_next;
      gap_to_run       <= gap_to_run_next;
      rsp_data_r       <= rsp_data_next;
      rsp_err_r        <= rsp_err_next;
    end
  end

  always_comb begin
    state_next            = state;
    job_next              = job;
    owner_next            = owner;
    key_cached_valid_next = key_cached_valid;
    cached_key_next       = cached_key;
    tmo_cnt_next          = tmo_cnt;
    gap_to_run_next       = gap_to_run;
    rsp_data_next         = rsp_data_r;
    rsp_err_next          = rsp_err_r;

    case (state)
      IDLE: begin
        if (|req) begin
          owner_next    = arb_win;
          job_next.dec  = req_dec[arb_win];
          job_next.data = data_sel;
          job_next.key  = key_sel;
          tmo_cnt_next  = '0;
          if (key_cached_valid && (key_sel == cached_key)) begin
            state_next = RUN;
          end else begin
            state_next = KEY;
          end
        end
      end

      KEY: begin
        // A done arriving in the same cycle as the timeout still counts as success.
        if (kx_done) begin
          cached_key_next       = job.key;
          key_cached_valid_next = 1'b1;
          gap_to_run_next       = 1'b1;
          state_next            = GAP;
        end else if (tmo_hit) begin
          rsp_err_next          = 1'b1;
          rsp_data_next         = '0;
          key_cached_valid_next = 1'b0;
          state_next            = RESP;
        end else begin
          tmo_cnt_next = tmo_cnt + 1'b1;
        end
      end

      GAP: begin
        if (gap_to_run) begin
          tmo_cnt_next = '0;
          state_next   = RUN;
        end else begin
          state_next = IDLE;
        end
      end

      RUN: begin
        if (done_match) begin
          rsp_data_next = (job.dec == MODE_DEC) ? dec_out : enc_out;
          rsp_err_next  = 1'b0;
          state_next    = RESP;
        end else if (tmo_hit) begin
          rsp_err_next          = 1'b1;
          rsp_data_next         = '0;
          key_cached_valid_next = 1'b0;
          state_next            = RESP;
        end else begin
          tmo_cnt_next = tmo_cnt + 1'b1;
        end
      end

      RESP: begin
        if (rsp_ack[owner]) begin
          gap_to_run_next = 1'b0;
          state_next      = GAP;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Grant is combinational so it appears in the first IDLE cycle a request is seen.
  assign gnt       = ((state == IDLE) && rst) ? arb_grant : 2'b00;
  assign kx_en     = (state == KEY) || (state == RUN);
  assign kx_key    = kx_en ? job.key[KW-1:0] : '0;
  assign enc_en    = (state == RUN) && (job.dec == MODE_ENC);
  assign dec_en    = (state == RUN) && (job.dec == MODE_DEC);
  assign eng_data  = (state == RUN) ? job.data : '0;
  assign rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data  = (state == RESP) ? rsp_data_r : '0;
  assign rsp_err   = (state == RESP) && rsp_err_r;

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Self-checking bench: behavioural engine model, scoreboard of expected responses per grant.
module tb_aes_job_scheduler;

  localparam int NK      = 4;
  localparam int KW      = NK * 32;
  localparam int TMO     = 16;
  localparam int KX_LAT  = 5;
  localparam int ENC_LAT = 7;
  localparam int DEC_LAT = 9;

  localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] MIX    = 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req, req_dec, gnt, rsp_valid, rsp_ack;
  logic [255:0]   req_data;
  logic [2*KW-1:0] req_key;
  logic [127:0]   rsp_data, eng_data, enc_out, dec_out;
  logic           rsp_err, kx_en, kx_done, enc_en, dec_en, enc_done, dec_done;
  logic [KW-1:0]  kx_key;

  always #5 clk = ~clk;

  aes_job_scheduler #(.Nk(NK), .Nr(10), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_dec(req_dec), .req_data(req_data),
    .req_key(req_key), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .kx_en(kx_en), .kx_key(kx_key),
    .kx_done(kx_done), .enc_en(enc_en), .dec_en(dec_en), .eng_data(eng_data),
    .enc_done(enc_done), .dec_done(dec_done), .enc_out(enc_out), .dec_out(dec_out)
  );

  // Stand-in cipher: exact FIPS-197 C.1 vector, otherwise an invertible scramble.
  function automatic logic [127:0] mock_enc(input logic [127:0] d, input logic [127:0] k);
    if (k == FIPS_K && d == FIPS_P) return FIPS_C;
    return {d[63:0], d[127:64]} ^ k ^ MIX;
  endfunction

  function automatic logic [127:0] mock_dec(input logic [127:0] d, input logic [127:0] k);
    logic [127:0] x;
    if (k == FIPS_K && d == FIPS_C) return FIPS_P;
    x = d ^ k ^ MIX;
    return {x[63:0], x[127:64]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Engine model: the cipher uses the key it expanded, so a wrong cache hit shows up in data.
  int           kx_cnt = 0, enc_cnt = 0, dec_cnt = 0;
  logic [127:0] ek = '0;
  logic         stall_enc = 1'b0, noise = 1'b0;

  always @(posedge clk) begin
    kx_cnt  <= kx_en ? kx_cnt + 1 : 0;
    enc_cnt <= enc_en ? enc_cnt + 1 : 0;
    dec_cnt <= dec_en ? dec_cnt + 1 : 0;
    if (kx_en && !enc_en && !dec_en && kx_cnt == KX_LAT - 1) ek <= kx_key;
  end

  assign kx_done  = kx_en && (kx_cnt >= KX_LAT);
  assign enc_done = (enc_en && (enc_cnt >= ENC_LAT) && !stall_enc) || (noise && dec_en);
  assign dec_done = (dec_en && (dec_cnt >= DEC_LAT)) || (noise && enc_en);
  assign enc_out  = mock_enc(eng_data, ek);
  assign dec_out  = mock_dec(eng_data, ek);

  typedef struct {
    logic         owner;
    logic [127:0] data;
    logic         err;
  } exp_t;

  exp_t       sb[$];
  int         grant_log[$];
  int         n_checks = 0, n_errors = 0;
  int         done_count = 0, key_cycles = 0, run_cycles = 0;
  logic       ack_block = 1'b0;
  logic [1:0] pending_clear = 2'b00;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic submit(input int i, input logic dec, input logic [127:0] d, input logic [127:0] k);
    req_dec[i]          = dec;
    req_data[i*128+:128] = d;
    req_key[i*KW+:KW]    = k;
    req[i]              = 1'b1;
  endtask

  task automatic monitor();
    exp_t         e;
    int           w;
    logic [127:0] d, k;
    if (kx_en && !enc_en && !dec_en) key_cycles++;
    if (enc_en || dec_en) run_cycles++;
    if (gnt != 2'b00) begin
      check("gnt_onehot", 128'($onehot(gnt)), 128'd1);
      w       = gnt[1] ? 1 : 0;
      d       = req_data[w*128+:128];
      k       = req_key[w*KW+:KW];
      e.owner = gnt[1];
      e.err   = stall_enc && !req_dec[w];
      e.data  = e.err ? 128'd0 : (req_dec[w] ? mock_dec(d, k) : mock_enc(d, k));
      sb.push_back(e);
      grant_log.push_back(w);
      pending_clear = pending_clear | gnt;
      $display("grant req%0d dec=%0b data=%h", w, req_dec[w], d);
    end
    rsp_ack = 2'b00;
    if (rsp_valid != 2'b00) begin
      if (ack_block) begin
        rsp_ack = ~rsp_valid;
      end else begin
        check("rsp_onehot", 128'($onehot(rsp_valid)), 128'd1);
        if (sb.size() == 0) begin
          check("sb_nonempty", 128'd0, 128'd1);
        end else begin
          e = sb.pop_front();
          check("rsp_owner", 128'(rsp_valid[1]), 128'(e.owner));
          check("rsp_data", rsp_data, e.data);
          check("rsp_err", 128'(rsp_err), 128'(e.err));
        end
        $display("response valid=%b data=%h err=%0b", rsp_valid, rsp_data, rsp_err);
        rsp_ack = rsp_valid;
        done_count++;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (pending_clear[i]) begin
        req[i]               = 1'b0;
        req_data[i*128+:128] = rand128();
      end
    end
    pending_clear = 2'b00;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_count < target && n < budget) begin
      step();
      n++;
    end
    if (done_count < target) check("wait_done", 128'(done_count), 128'(target));
  endtask

  task automatic wait_run(input int budget);
    int n = 0;
    while (!(enc_en || dec_en) && n < budget) begin
      step();
      n++;
    end
    check("wait_run", 128'(enc_en || dec_en), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [127:0] last_key, d0, dr;
    int           stable_bad, nlog, n;

    rst = 1'b0; req = '0; req_dec = '0; req_data = '0; req_key = '0; rsp_ack = '0;
    step();
    step();
    check("rst_ctrl", 128'({gnt, rsp_valid, rsp_err, kx_en, enc_en, dec_en}), 128'd0);
    check("rst_kx_key", 128'(kx_key), 128'd0);
    check("rst_eng_data", eng_data, 128'd0);
    check("rst_rsp_data", rsp_data, 128'd0);
    rst = 1'b1;
    step();

    // FIPS-197 C.1 encrypt: cold cache, key expansion must run.
    key_cycles = 0;
    submit(0, 1'b0, FIPS_P, FIPS_K);
    wait_done(1, 300);
    check("enc_key_cycles", 128'(key_cycles), 128'(KX_LAT + 1));

    // Decrypt with the same key from the other requester: cache hit, stray enc_done ignored.
    key_cycles = 0;
    noise = 1'b1;
    submit(1, 1'b1, FIPS_C, FIPS_K);
    wait_done(2, 300);
    noise = 1'b0;
    check("dec_cache_hit", 128'(key_cycles), 128'd0);

    // Two rounds of simultaneous requests.
    grant_log.delete();
    last_key = '0;
    for (int r = 0; r < 2; r++) begin
      submit(0, 1'($urandom_range(0, 1)), rand128(), rand128());
      last_key = rand128();
      submit(1, 1'($urandom_range(0, 1)), rand128(), last_key);
      wait_done(done_count + 2, 600);
    end
    check("rr_count", 128'(grant_log.size()), 128'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) check($sformatf("rr_order%0d", i), 128'(grant_log[i]), 128'(i % 2));
    end

    // Stalled cipher on a cached key: timeout after counting 0..TMO in RUN.
    stall_enc  = 1'b1;
    run_cycles = 0;
    key_cycles = 0;
    submit(0, 1'b0, rand128(), last_key);
    wait_done(done_count + 1, 300);
    stall_enc = 1'b0;
    check("tmo_hit_no_key", 128'(key_cycles), 128'd0);
    check("tmo_run_cycles", 128'(run_cycles), 128'(TMO + 1));
    key_cycles = 0;
    submit(1, 1'b0, rand128(), last_key);
    wait_done(done_count + 1, 300);
    check("tmo_rekey", 128'(key_cycles != 0), 128'd1);

    // Backpressure: owner withholds ack, the other requester acks and waits.
    ack_block = 1'b1;
    submit(0, 1'b0, rand128(), last_key);
    n = 0;
    while (rsp_valid == 2'b00 && n < 300) begin
      step();
      n++;
    end
    check("bp_valid", 128'(rsp_valid), 128'd1);
    d0 = rsp_data;
    submit(1, 1'b1, rand128(), last_key);
    nlog = grant_log.size();
    stable_bad = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (rsp_valid !== 2'b01 || rsp_data !== d0) stable_bad++;
    end
    check("bp_stable", 128'(stable_bad), 128'd0);
    check("bp_no_grant", 128'(grant_log.size() - nlog), 128'd0);
    ack_block = 1'b0;
    wait_done(done_count + 2, 400);
    check("bp_late_grant", 128'(grant_log.size() - nlog), 128'd1);

    // Reset in the middle of RUN abandons the job; re-grant must expand the key again.
    dr = rand128();
    submit(0, 1'b0, dr, last_key);
    wait_run(300);
    step();
    rst = 1'b0;
    submit(0, 1'b0, dr, last_key);
    #1;
    check("mid_rst_ctrl", 128'({gnt, rsp_valid, rsp_err, kx_en, enc_en, dec_en}), 128'd0);
    check("mid_rst_kx_key", 128'(kx_key), 128'd0);
    check("mid_rst_eng_data", eng_data, 128'd0);
    sb.delete();
    step();
    step();
    rst = 1'b1;
    key_cycles = 0;
    nlog = grant_log.size();
    wait_done(done_count + 1, 300);
    check("rst_regrant", 128'(grant_log.size() - nlog), 128'd1);
    check("rst_rekey", 128'(key_cycles != 0), 128'd1);

    step();
    check("sb_drained", 128'(sb.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
